hazard_unit_mc: RTL and testbench

- Next-generation hazard and forwarding controller for the 5-stage RV32 pipeline. Branches resolve in ID.
- Forwards EX/MEM/WB results to the ID operands.
- Inserts a configurable number of load-use bubbles using a counter FSM.
- Freezes the whole pipeline while the data memory is not ready, gates branch flush, and keeps stall/flush performance counters.

---
 rtl/hazard_unit_mc_if.sv | 51 +++++
 rtl/hazard_unit_mc.sv | 139 +++++++++++++
 tb/tb_hazard_unit_mc.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_unit_mc_if.sv
// Signal bundle between the ID-stage pipeline control and the hazard/forwarding unit.
// The pipeline drives stage state (master); the hazard unit returns operands and controls (slave).
interface hazard_unit_mc_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned REGW  = 5,
  parameter int unsigned CNT_W = 32
);
  logic [REGW-1:0]  id_rs1;
  logic [REGW-1:0]  id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [XLEN-1:0]  id_rd1;
  logic [XLEN-1:0]  id_rd2;
  logic [REGW-1:0]  ex_wr;
  logic [REGW-1:0]  mem_wr;
  logic [REGW-1:0]  wb_wr;
  logic             ex_we;
  logic             mem_we;
  logic             wb_we;
  logic             ex_is_load;
  logic             mem_is_load;
  logic [XLEN-1:0]  ex_wd;
  logic [XLEN-1:0]  mem_wd;
  logic [XLEN-1:0]  wb_wd;
  logic             mem_ready;
  logic             id_branch_taken;
  logic [XLEN-1:0]  fwd_rd1;
  logic [XLEN-1:0]  fwd_rd2;
  logic             hold_pc_ifid;
  logic             bubble_idex;
  logic             freeze_all;
  logic             flush_ifid;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd1, id_rd2,
    output ex_wr, mem_wr, wb_wr, ex_we, mem_we, wb_we, ex_is_load, mem_is_load,
    output ex_wd, mem_wd, wb_wd, mem_ready, id_branch_taken,
    input  fwd_rd1, fwd_rd2, hold_pc_ifid, bubble_idex, freeze_all, flush_ifid,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd1, id_rd2,
    input  ex_wr, mem_wr, wb_wr, ex_we, mem_we, wb_we, ex_is_load, mem_is_load,
    input  ex_wd, mem_wd, wb_wd, mem_ready, id_branch_taken,
    output fwd_rd1, fwd_rd2, hold_pc_ifid, bubble_idex, freeze_all, flush_ifid,
    output stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_unit_mc.sv
// Hazard and forwarding controller for a 5-stage RV32 pipeline with branches resolved in ID:
// operand forwarding, multi-cycle load-use bubbles, memory-wait freeze and stall/flush counters.
module hazard_unit_mc #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned REGW     = 5,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CNT_W    = 32
) (
  input logic           clk,
  input logic           rst_n,
  hazard_unit_mc_if.slave hz
);

  typedef enum logic [1:0] {StRun = 2'd0, StLuWait = 2'd1, StFreeze = 2'd2} state_e;

  // The detect cycle is the first bubble; LU_WAIT supplies the remaining LOAD_LAT-1 and
  // lu_cnt counts the LU_WAIT cycles still to come after the current one.
  localparam int unsigned WaitCycles = (LOAD_LAT > 1) ? LOAD_LAT - 1 : 0;
  localparam logic [1:0]  LuCntInit  = (WaitCycles > 0) ? 2'(WaitCycles - 1) : 2'd0;
  localparam logic        MemLoadFwd = (LOAD_LAT == 1);

  function automatic logic src_match(input logic use_src, input logic we,
                                     input logic [REGW-1:0] wr, input logic [REGW-1:0] rs);
    return use_src && we && (wr == rs) && (wr != '0);
  endfunction

  // A skipped stage still wins priority; the register-file value it returns is stale but
  // unused because the stall keeps the instruction in ID.
  function automatic logic [XLEN-1:0] fwd_pick(input logic m_ex, input logic m_mem,
                                               input logic m_wb, input logic [XLEN-1:0] rf,
                                               input logic [XLEN-1:0] exd,
                                               input logic [XLEN-1:0] memd,
                                               input logic [XLEN-1:0] wbd,
                                               input logic ex_skp, input logic mem_skp);
    if (m_ex)  return ex_skp ? rf : exd;
    if (m_mem) return mem_skp ? rf : memd;
    if (m_wb)  return wbd;
    return rf;
  endfunction

  logic m_ex_rs1, m_ex_rs2, m_mem_rs1, m_mem_rs2, m_wb_rs1, m_wb_rs2;
  logic ex_skip, mem_skip, lu, mem_stall;

  assign m_ex_rs1  = src_match(hz.id_use_rs1, hz.ex_we, hz.ex_wr, hz.id_rs1);
  assign m_ex_rs2  = src_match(hz.id_use_rs2, hz.ex_we, hz.ex_wr, hz.id_rs2);
  assign m_mem_rs1 = src_match(hz.id_use_rs1, hz.mem_we, hz.mem_wr, hz.id_rs1);
  assign m_mem_rs2 = src_match(hz.id_use_rs2, hz.mem_we, hz.mem_wr, hz.id_rs2);
  assign m_wb_rs1  = src_match(hz.id_use_rs1, hz.wb_we, hz.wb_wr, hz.id_rs1);
  assign m_wb_rs2  = src_match(hz.id_use_rs2, hz.wb_we, hz.wb_wr, hz.id_rs2);

  assign ex_skip   = hz.ex_is_load;
  assign mem_skip  = hz.mem_is_load && !MemLoadFwd;
  assign lu        = hz.ex_is_load && (m_ex_rs1 || m_ex_rs2);
  assign mem_stall = hz.mem_is_load && !hz.mem_ready;

  assign hz.fwd_rd1 = fwd_pick(m_ex_rs1, m_mem_rs1, m_wb_rs1, hz.id_rd1, hz.ex_wd, hz.mem_wd,
                               hz.wb_wd, ex_skip, mem_skip);
  assign hz.fwd_rd2 = fwd_pick(m_ex_rs2, m_mem_rs2, m_wb_rs2, hz.id_rd2, hz.ex_wd, hz.mem_wd,
                               hz.wb_wd, ex_skip, mem_skip);

  state_e     state_q, state_d, resume_q, resume_d;
  logic [1:0] lu_cnt_q, lu_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StRun;
      resume_q <= StRun;
      lu_cnt_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      resume_q <= resume_d;
      lu_cnt_q <= lu_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    resume_d = resume_q;
    lu_cnt_d = lu_cnt_q;
    unique case (state_q)
      StRun: begin
        if (mem_stall) begin
          state_d  = StFreeze;
          resume_d = StRun;
        end else if (lu && (WaitCycles != 0)) begin
          state_d  = StLuWait;
          lu_cnt_d = LuCntInit;
        end
      end
      StLuWait: begin
        if (mem_stall) begin
          state_d  = StFreeze;
          resume_d = StLuWait;
        end else if (lu_cnt_q == 2'd0) begin
          state_d = StRun;
        end else begin
          lu_cnt_d = lu_cnt_q - 2'd1;
        end
      end
      StFreeze: begin
        if (hz.mem_ready) state_d = resume_q;
      end
      default: state_d = StRun;
    endcase
  end

  logic freeze, lu_run, in_lu_wait, hold, bubble, flush;

  // Gated by rst_n so the controls read 0 for the whole reset window, not just after an edge.
  always_comb begin
    lu_run     = (state_q == StRun) && lu;
    in_lu_wait = (state_q == StLuWait);
    freeze     = rst_n && ((state_q == StFreeze) || mem_stall);
    hold       = rst_n && (freeze || lu_run || in_lu_wait);
    bubble     = rst_n && !freeze && (lu_run || in_lu_wait);
    flush      = rst_n && hz.id_branch_taken && !hold;
  end

  assign hz.freeze_all   = freeze;
  assign hz.hold_pc_ifid = hold;
  assign hz.bubble_idex  = bubble;
  assign hz.flush_ifid   = flush;

  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(hold);
      flush_cnt_q <= flush_cnt_q + CNT_W'(flush);
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed bench for hazard_unit_mc: forwarding vector table on LOAD_LAT=1/2 instances plus
// hand sequences for load-use bubbles, memory freeze, branch gating and mid-stall reset.
module tb_hazard_unit_mc;

  localparam logic [31:0] RD1  = 32'h1000_0001;
  localparam logic [31:0] RD2  = 32'h2000_0002;
  localparam logic [31:0] EXD  = 32'h0000_0011;
  localparam logic [31:0] MEMD = 32'h0000_0022;
  localparam logic [31:0] WBD  = 32'h0000_0033;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  hazard_unit_mc_if #(.XLEN(32), .REGW(5), .CNT_W(32)) if1 ();
  hazard_unit_mc_if #(.XLEN(32), .REGW(5), .CNT_W(32)) if2 ();

  hazard_unit_mc #(.XLEN(32), .REGW(5), .LOAD_LAT(1), .CNT_W(32)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (if1)
  );

  hazard_unit_mc #(.XLEN(32), .REGW(5), .LOAD_LAT(2), .CNT_W(32)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (if2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Both instances see the same stimulus.
  always_comb begin
    if2.id_rs1          = if1.id_rs1;
    if2.id_rs2          = if1.id_rs2;
    if2.id_use_rs1      = if1.id_use_rs1;
    if2.id_use_rs2      = if1.id_use_rs2;
    if2.id_rd1          = if1.id_rd1;
    if2.id_rd2          = if1.id_rd2;
    if2.ex_wr           = if1.ex_wr;
    if2.mem_wr          = if1.mem_wr;
    if2.wb_wr           = if1.wb_wr;
    if2.ex_we           = if1.ex_we;
    if2.mem_we          = if1.mem_we;
    if2.wb_we           = if1.wb_we;
    if2.ex_is_load      = if1.ex_is_load;
    if2.mem_is_load     = if1.mem_is_load;
    if2.ex_wd           = if1.ex_wd;
    if2.mem_wd          = if1.mem_wd;
    if2.wb_wd           = if1.wb_wd;
    if2.mem_ready       = if1.mem_ready;
    if2.id_branch_taken = if1.id_branch_taken;
  end

  typedef struct {
    logic [4:0]  rs1, rs2;
    logic        use1, use2;
    logic [4:0]  ex_wr;
    logic        ex_we, ex_ld;
    logic [4:0]  mem_wr;
    logic        mem_we, mem_ld;
    logic [4:0]  wb_wr;
    logic        wb_we;
    logic        lat2;
    logic [31:0] e1, e2;
    logic        ehold, ebub;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic idle();
    if1.id_rs1 = 5'd0;          if1.id_rs2 = 5'd0;
    if1.id_use_rs1 = 1'b0;      if1.id_use_rs2 = 1'b0;
    if1.id_rd1 = RD1;           if1.id_rd2 = RD2;
    if1.ex_wr = 5'd0;           if1.ex_we = 1'b0;   if1.ex_is_load = 1'b0;
    if1.mem_wr = 5'd0;          if1.mem_we = 1'b0;  if1.mem_is_load = 1'b0;
    if1.wb_wr = 5'd0;           if1.wb_we = 1'b0;
    if1.ex_wd = EXD;            if1.mem_wd = MEMD;  if1.wb_wd = WBD;
    if1.mem_ready = 1'b1;       if1.id_branch_taken = 1'b0;
  endtask

  // ID add reads x7 in rs2 while EX holds lw x7.
  task automatic set_lu();
    if1.id_rs2 = 5'd7; if1.id_use_rs2 = 1'b1;
    if1.ex_wr = 5'd7;  if1.ex_we = 1'b1; if1.ex_is_load = 1'b1;
  endtask

  // The lw x7 has moved to MEM, a bubble sits in EX.
  task automatic set_mem_load(input logic ready);
    if1.id_rs2 = 5'd7; if1.id_use_rs2 = 1'b1;
    if1.mem_wr = 5'd7; if1.mem_we = 1'b1; if1.mem_is_load = 1'b1;
    if1.mem_wd = 32'h0000_ABCD; if1.mem_ready = ready;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          rs1    rs2    u1    u2    exwr   we    ld    memwr  we    ld    wbwr   we    l2    e1    e2    hold  bub
    vecs[0]  = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, EXD,  RD2,  1'b0, 1'b0};
    vecs[1]  = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, MEMD, RD2,  1'b0, 1'b0};
    vecs[2]  = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, WBD,  RD2,  1'b0, 1'b0};
    vecs[3]  = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, RD1,  RD2,  1'b0, 1'b0};
    vecs[4]  = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, RD1,  RD2,  1'b0, 1'b0};
    vecs[5]  = '{5'd5, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, MEMD, RD2,  1'b1, 1'b1};
    vecs[6]  = '{5'd0, 5'd7, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, RD1,  MEMD, 1'b0, 1'b0};
    vecs[7]  = '{5'd0, 5'd7, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b1, RD1,  RD2,  1'b0, 1'b0};
    vecs[8]  = '{5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, RD1,  RD2,  1'b0, 1'b0};
    vecs[9]  = '{5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, EXD,  EXD,  1'b0, 1'b0};
    vecs[10] = '{5'd0, 5'd3, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, RD1,  MEMD, 1'b0, 1'b0};
    vecs[11] = '{5'd0, 5'd4, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, RD1,  MEMD, 1'b0, 1'b0};

    // Controls must stay low during reset even with a load-use and a memory stall present.
    rst_n = 1'b0;
    idle();
    set_lu();
    if1.mem_is_load = 1'b1; if1.mem_ready = 1'b0; if1.id_branch_taken = 1'b1;
    #12;
    check("rst_hold", {31'd0, if1.hold_pc_ifid}, 32'd0);
    check("rst_freeze", {31'd0, if2.freeze_all}, 32'd0);
    check("rst_bubble", {31'd0, if1.bubble_idex}, 32'd0);
    check("rst_flush", {31'd0, if1.flush_ifid}, 32'd0);
    check("rst_stall_cnt", if1.stall_cnt, 32'd0);
    check("rst_flush_cnt", if2.flush_cnt, 32'd0);
    @(negedge clk);
    idle();
    rst_n = 1'b1;

    // Combinational forwarding table; inputs return to idle before every posedge.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if1.id_rs1 = vecs[i].rs1;     if1.id_rs2 = vecs[i].rs2;
      if1.id_use_rs1 = vecs[i].use1; if1.id_use_rs2 = vecs[i].use2;
      if1.ex_wr = vecs[i].ex_wr;    if1.ex_we = vecs[i].ex_we;   if1.ex_is_load = vecs[i].ex_ld;
      if1.mem_wr = vecs[i].mem_wr;  if1.mem_we = vecs[i].mem_we; if1.mem_is_load = vecs[i].mem_ld;
      if1.wb_wr = vecs[i].wb_wr;    if1.wb_we = vecs[i].wb_we;
      #1;
      if (vecs[i].lat2) begin
        check($sformatf("vec%0d_fwd1", i), if2.fwd_rd1, vecs[i].e1);
        check($sformatf("vec%0d_fwd2", i), if2.fwd_rd2, vecs[i].e2);
        check($sformatf("vec%0d_hold", i), {31'd0, if2.hold_pc_ifid}, {31'd0, vecs[i].ehold});
        check($sformatf("vec%0d_bubble", i), {31'd0, if2.bubble_idex}, {31'd0, vecs[i].ebub});
      end else begin
        check($sformatf("vec%0d_fwd1", i), if1.fwd_rd1, vecs[i].e1);
        check($sformatf("vec%0d_fwd2", i), if1.fwd_rd2, vecs[i].e2);
        check($sformatf("vec%0d_hold", i), {31'd0, if1.hold_pc_ifid}, {31'd0, vecs[i].ehold});
        check($sformatf("vec%0d_bubble", i), {31'd0, if1.bubble_idex}, {31'd0, vecs[i].ebub});
      end
      idle();
    end

    // LOAD_LAT=1: one bubble, then MEM-stage load data forwarded.
    do_reset();
    @(negedge clk);
    idle(); set_lu();
    #1;
    check("l1_detect_hold", {31'd0, if1.hold_pc_ifid}, 32'd1);
    check("l1_detect_bubble", {31'd0, if1.bubble_idex}, 32'd1);
    check("l1_detect_freeze", {31'd0, if1.freeze_all}, 32'd0);
    @(negedge clk);
    idle(); set_mem_load(1'b1);
    #1;
    check("l1_mem_fwd2", if1.fwd_rd2, 32'h0000_ABCD);
    check("l1_release_hold", {31'd0, if1.hold_pc_ifid}, 32'd0);
    check("l1_release_bubble", {31'd0, if1.bubble_idex}, 32'd0);
    check("l1_stall_cnt", if1.stall_cnt, 32'd1);

    // LOAD_LAT=2: two bubbles, MEM load data not forwarded, WB supplies it.
    do_reset();
    @(negedge clk);
    idle(); set_lu();
    #1;
    check("l2_detect_bubble", {31'd0, if2.bubble_idex}, 32'd1);
    @(negedge clk);
    idle(); set_mem_load(1'b1);
    #1;
    check("l2_wait_hold", {31'd0, if2.hold_pc_ifid}, 32'd1);
    check("l2_wait_bubble", {31'd0, if2.bubble_idex}, 32'd1);
    check("l2_mem_not_fwd", if2.fwd_rd2, RD2);
    @(negedge clk);
    idle();
    if1.id_rs2 = 5'd7; if1.id_use_rs2 = 1'b1;
    if1.wb_wr = 5'd7; if1.wb_we = 1'b1; if1.wb_wd = 32'h0000_5555;
    #1;
    check("l2_release_hold", {31'd0, if2.hold_pc_ifid}, 32'd0);
    check("l2_release_bubble", {31'd0, if2.bubble_idex}, 32'd0);
    check("l2_wb_fwd2", if2.fwd_rd2, 32'h0000_5555);
    check("l2_stall_cnt", if2.stall_cnt, 32'd2);

    // LOAD_LAT=2 with memory not ready during LU_WAIT: freeze, then the held bubble.
    do_reset();
    @(negedge clk);
    idle(); set_lu();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      idle(); set_mem_load(1'b0);
      #1;
      check($sformatf("frz%0d_freeze", c), {31'd0, if2.freeze_all}, 32'd1);
      check($sformatf("frz%0d_bubble", c), {31'd0, if2.bubble_idex}, 32'd0);
      check($sformatf("frz%0d_hold", c), {31'd0, if2.hold_pc_ifid}, 32'd1);
    end
    @(negedge clk);
    idle(); set_mem_load(1'b1);
    #1;
    check("frz_exit_freeze", {31'd0, if2.freeze_all}, 32'd1);
    check("frz_exit_bubble", {31'd0, if2.bubble_idex}, 32'd0);
    @(negedge clk);
    #1;
    check("frz_resume_freeze", {31'd0, if2.freeze_all}, 32'd0);
    check("frz_resume_bubble", {31'd0, if2.bubble_idex}, 32'd1);
    @(negedge clk);
    idle();
    #1;
    check("frz_done_bubble", {31'd0, if2.bubble_idex}, 32'd0);
    check("frz_done_hold", {31'd0, if2.hold_pc_ifid}, 32'd0);
    check("frz_stall_cnt", if2.stall_cnt, 32'd6);

    // Branch taken while waiting on a load operand: flush only after the stall.
    do_reset();
    @(negedge clk);
    idle(); set_lu(); if1.id_branch_taken = 1'b1;
    #1;
    check("br_detect_flush", {31'd0, if2.flush_ifid}, 32'd0);
    @(negedge clk);
    idle(); set_mem_load(1'b1); if1.id_branch_taken = 1'b1;
    #1;
    check("br_wait_flush", {31'd0, if2.flush_ifid}, 32'd0);
    @(negedge clk);
    idle(); if1.id_branch_taken = 1'b1;
    #1;
    check("br_run_flush", {31'd0, if2.flush_ifid}, 32'd1);
    check("br_cnt_before", if2.flush_cnt, 32'd0);
    @(negedge clk);
    idle();
    #1;
    check("br_flush_cnt", if2.flush_cnt, 32'd1);
    check("br_flush_low", {31'd0, if2.flush_ifid}, 32'd0);

    // Reset asserted mid-LU_WAIT clears everything and returns to RUN.
    do_reset();
    @(negedge clk);
    idle(); set_lu();
    @(negedge clk);
    idle(); set_mem_load(1'b1); if1.id_branch_taken = 1'b1;
    #1;
    check("rmid_pre_bubble", {31'd0, if2.bubble_idex}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rmid_hold", {31'd0, if2.hold_pc_ifid}, 32'd0);
    check("rmid_bubble", {31'd0, if2.bubble_idex}, 32'd0);
    check("rmid_freeze", {31'd0, if2.freeze_all}, 32'd0);
    check("rmid_flush", {31'd0, if2.flush_ifid}, 32'd0);
    check("rmid_stall_cnt", if2.stall_cnt, 32'd0);
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("rmid_run_hold", {31'd0, if2.hold_pc_ifid}, 32'd0);
    check("rmid_run_bubble", {31'd0, if2.bubble_idex}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
